fifo_uart_tx: RTL and testbench

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx_if.sv | 31 +++
 rtl/fifo_uart_tx.sv | 149 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// Handshake/serial bundle between fifo_uart_tx and its FIFO/line environment.
// master = transmitter side, slave = FIFO and line side.
interface fifo_uart_tx_if;
  logic        tx_en;
  logic [7:0]  fifo_count;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        tx;
  logic        busy;
  logic [15:0] bytes_sent;

  modport master (
    input  tx_en,
    input  fifo_count,
    input  fifo_data,
    output fifo_rd_en,
    output tx,
    output busy,
    output bytes_sent
  );

  modport slave (
    output tx_en,
    output fifo_count,
    output fifo_data,
    input  fifo_rd_en,
    input  tx,
    input  busy,
    input  bytes_sent
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an upstream FIFO and sends 8N1 UART frames, LSB first.
// Define PARITY_EN to insert an even-parity bit between data bit 7 and the stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic            clk,
  input logic            rst,
  fifo_uart_tx_if.master bus
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LATCH  = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [2:0]    bit_r, bit_s;
  logic [7:0]    shift_r, shift_s;
  logic [15:0]   sent_r, sent_s;
  logic          tx_r, tx_s;
  logic          rd_r, rd_s;
  logic          busy_r, busy_s;
  logic          last_s;
`ifdef PARITY_EN
  logic          parity_r, parity_s;
`endif

  // Next-state, datapath and next-output decode; outputs are registered from the next state
  always_comb begin
    state_s = state_r;
    bit_s   = bit_r;
    shift_s = shift_r;
    sent_s  = sent_r;
    last_s  = (cnt_r == CNT_LAST);
`ifdef PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        if (bus.tx_en && (bus.fifo_count != 8'd0)) state_s = FETCH;
        else                                        state_s = IDLE;
      end
      FETCH: state_s = LATCH;
      LATCH: begin
        shift_s = bus.fifo_data;
`ifdef PARITY_EN
        parity_s = ^bus.fifo_data;
`endif
        state_s = START;
      end
      START: begin
        if (last_s) begin
          state_s = DATA;
          bit_s   = 3'd0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (last_s) begin
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_r == 3'd7) begin
`ifdef PARITY_EN
            state_s = PARITY;
`else
            state_s = STOP;
`endif
          end else begin
            bit_s = bit_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (last_s) state_s = STOP;
        else        state_s = PARITY;
      end
`endif
      STOP: begin
        if (last_s) begin
          sent_s  = sent_r + 16'd1;
          state_s = IDLE;
        end else begin
          state_s = STOP;
        end
      end
      default: state_s = IDLE;
    endcase

    // Each bit period, and every state entry, starts the counter from zero
    if ((state_s != state_r) || last_s) cnt_s = '0;
    else                                cnt_s = cnt_r + CW'(1);

    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shift_s[0];
`ifdef PARITY_EN
      PARITY:  tx_s = parity_s;
`endif
      default: tx_s = 1'b1;
    endcase
    rd_s   = (state_s == FETCH);
    busy_s = (state_s != IDLE);
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      bit_r    <= 3'd0;
      shift_r  <= 8'd0;
      sent_r   <= 16'd0;
      tx_r     <= 1'b1;
      rd_r     <= 1'b0;
      busy_r   <= 1'b0;
`ifdef PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      bit_r    <= bit_s;
      shift_r  <= shift_s;
      sent_r   <= sent_s;
      tx_r     <= tx_s;
      rd_r     <= rd_s;
      busy_r   <= busy_s;
`ifdef PARITY_EN
      parity_r <= parity_s;
`endif
    end
  end

  assign bus.tx         = tx_r;
  assign bus.fifo_rd_en = rd_r;
  assign bus.busy       = busy_r;
  assign bus.bytes_sent = sent_r;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, table-driven frames, random bytes,
// tx_en hold-off and reset-abandon sequences, all checked cycle by cycle at negedge.
module tb_fifo_uart_tx;
  localparam int C = 4;
`ifdef PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [0:9] f10;
    logic       par;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   exp_sent = 0;
  logic [7:0] fifo_q[$];
  vec_t tbl[7];
  logic [7:0] r1, r2, rd;
  logic [7:0] rb[4];

  fifo_uart_tx_if bus();

  fifo_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Upstream FIFO: data appears the cycle after rd_en is sampled
  always @(posedge clk) begin
    if (bus.fifo_rd_en && (fifo_q.size() > 0)) begin
      bus.fifo_data <= fifo_q[0];
      fifo_q.delete(0);
    end
    bus.fifo_count <= 8'(fifo_q.size());
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [0:9] model_frame(input logic [7:0] d);
    logic [0:9] f;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[k+1] = d[k];
    f[9] = 1'b1;
    return f;
  endfunction

  function automatic logic model_par(input logic [7:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  function automatic logic frame_bit(input logic [0:9] f, input logic par, input int p);
    if (NB == 11 && p == 9)       return par;
    else if (NB == 11 && p == 10) return f[9];
    else                          return f[p];
  endfunction

  task automatic wait_fetch(input bit strict);
    @(negedge clk);
    if (!strict) begin
      for (int i = 0; i < 300 && !bus.fifo_rd_en; i++) @(negedge clk);
    end
    chk("fetch_pulse", 32'(bus.fifo_rd_en), 32'd1);
  endtask

  task automatic check_frame(input logic [0:9] f10, input logic par, input bit strict, input int drop_at);
    wait_fetch(strict);
    chk("fetch_busy_tx", 32'({bus.busy, bus.tx}), 32'b11);
    @(negedge clk);
    chk("latch", 32'({bus.fifo_rd_en, bus.busy, bus.tx}), 32'b011);
    for (int p = 0; p < NB; p++) begin
      if (p == drop_at) tx_en_drop();
      for (int c = 0; c < C; c++) begin
        @(negedge clk);
        chk("frame_bit", 32'({bus.fifo_rd_en, bus.busy, bus.tx}),
            32'({2'b01, frame_bit(f10, par, p)}));
      end
    end
    exp_sent = (exp_sent + 1) % 65536;
    @(negedge clk);
    chk("idle_gap", 32'({bus.fifo_rd_en, bus.busy, bus.tx}), 32'b001);
    chk("bytes_sent", 32'(bus.bytes_sent), 32'(exp_sent));
  endtask

  task automatic tx_en_drop();
    bus.tx_en = 1'b0;
  endtask

  initial begin
    tbl[0] = '{8'hA5, 10'b0101001011, 1'b0};
    tbl[1] = '{8'h00, 10'b0000000001, 1'b0};
    tbl[2] = '{8'hFF, 10'b0111111111, 1'b0};
    tbl[3] = '{8'h3C, 10'b0001111001, 1'b0};
    tbl[4] = '{8'h07, 10'b0111000001, 1'b1};
    tbl[5] = '{8'h03, 10'b0110000001, 1'b0};
    tbl[6] = '{8'h55, 10'b0101010101, 1'b0};

    // Reset held two cycles while data is available and tx_en is high
    rst = 1'b0;
    bus.tx_en = 1'b1;
    for (int i = 0; i < 6; i++) fifo_q.push_back(tbl[i].data);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(bus.tx), 32'd1);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_bytes", 32'(bus.bytes_sent), 32'd0);
    rst = 1'b1;

    // Table frames, back to back after the first
    for (int i = 0; i < 6; i++) check_frame(tbl[i].f10, tbl[i].par, (i != 0), -1);

    // tx_en dropped during data bit 3 of 0x55: frame completes, then no fetch
    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    fifo_q.push_back(tbl[6].data);
    fifo_q.push_back(r1);
    fifo_q.push_back(r2);
    check_frame(tbl[6].f10, tbl[6].par, 1'b0, 4);
    repeat (30) begin
      @(negedge clk);
      chk("hold_off", 32'({bus.fifo_rd_en, bus.busy}), 32'b00);
    end
    bus.tx_en = 1'b1;
    check_frame(model_frame(r1), model_par(r1), 1'b0, -1);
    check_frame(model_frame(r2), model_par(r2), 1'b1, -1);

    // Random burst against the reference model
    for (int r = 0; r < 4; r++) begin
      rb[r] = 8'($urandom_range(0, 255));
      fifo_q.push_back(rb[r]);
    end
    for (int r = 0; r < 4; r++) check_frame(model_frame(rb[r]), model_par(rb[r]), (r != 0), -1);

    // Reset during data bit 3 abandons the frame
    rd = 8'hC3;
    fifo_q.push_back(rd);
    wait_fetch(1'b0);
    repeat (1 + 4 * C + 1) @(negedge clk);
    chk("pre_reset_bit3", 32'({bus.busy, bus.tx}), 32'({1'b1, rd[3]}));
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx", 32'(bus.tx), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("mid_rst_bytes", 32'(bus.bytes_sent), 32'd0);
    rst = 1'b1;
    exp_sent = 0;
    repeat (20) begin
      @(negedge clk);
      chk("post_rst_idle", 32'({bus.fifo_rd_en, bus.busy, bus.tx}), 32'b001);
    end
    rd = 8'($urandom_range(0, 255));
    fifo_q.push_back(rd);
    check_frame(model_frame(rd), model_par(rd), 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
